// File: rtl/aes_key_sequencer.sv
// aes_key_sequencer: fetches a 128-bit key word by word, launches the AES core and captures its result
// with an optional RUN-phase timeout that aborts to IDLE with a sticky error flag.
module aes_key_sequencer #(
    parameter int TIMEOUT = 1024
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         aes_start,
    input  logic [31:0]  AES_D0_I,
    input  logic [31:0]  AES_D1_I,
    input  logic [31:0]  AES_D2_I,
    input  logic [31:0]  AES_D3_I,
    input  logic [31:0]  AES_key_addr_I,
    output logic         mem_req,
    output logic [31:0]  mem_addr,
    input  logic [31:0]  mem_rdata,
    input  logic         mem_ack,
    output logic         core_start,
    output logic [127:0] core_key,
    output logic [127:0] core_din,
    input  logic [127:0] core_dout,
    input  logic         core_done,
    output logic [31:0]  AES_Res0_O,
    output logic [31:0]  AES_Res1_O,
    output logic [31:0]  AES_Res2_O,
    output logic [31:0]  AES_Res3_O,
    output logic         aes_done,
    output logic         busy,
    output logic         aes_err
);
    typedef enum logic [1:0] {IDLE, FETCH, RUN, DONE} state_t;
    state_t           state, state_d;
    logic [1:0]       idx;
    logic [31:0]      addr_q, tcnt;
    logic [3:0][31:0] key_q;
    logic [127:0]     din_q, res_q;
    logic             err_q, tmo;
    assign tmo = (TIMEOUT > 0) && (tcnt == 32'(TIMEOUT - 1));
    always_comb begin
        state_d = state == IDLE  ? (aes_start ? FETCH : IDLE) :
                  state == FETCH ? (mem_ack && idx == 2'd3 ? RUN : FETCH) :
                  state == RUN   ? (core_done ? DONE : tmo ? IDLE : RUN) : IDLE;
    end
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= IDLE;
        else       state <= state_d;
    end
    // key word 0 lands in the top slice, so word index i maps to packed element 3-i
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            idx    <= '0;
            addr_q <= '0;
            tcnt   <= '0;
            key_q  <= '0;
            din_q  <= '0;
            res_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state == IDLE && aes_start) begin
                din_q  <= {AES_D0_I, AES_D1_I, AES_D2_I, AES_D3_I};
                addr_q <= AES_key_addr_I;
                idx    <= '0;
                err_q  <= 1'b0;
            end
            if (state == FETCH && mem_ack) begin
                key_q[~idx] <= mem_rdata;
                idx         <= idx + 2'd1;
            end
            tcnt <= state == RUN ? tcnt + {31'd0, ~&tcnt} : '0;
            if (state == RUN && core_done) res_q <= core_dout;
            if (state == RUN && !core_done && tmo) err_q <= 1'b1;
        end
    end
    assign busy       = state != IDLE;
    assign mem_req    = state == FETCH;
    assign mem_addr   = addr_q + {28'd0, idx, 2'b00};
    assign core_start = state == RUN && tcnt == '0;
    assign core_key   = key_q;
    assign core_din   = din_q;
    assign aes_done   = state == DONE;
    assign aes_err    = err_q;
    assign AES_Res0_O = res_q[127:96];
    assign AES_Res1_O = res_q[95:64];
    assign AES_Res2_O = res_q[63:32];
    assign AES_Res3_O = res_q[31:0];
endmodule

// File: tb/tb_aes_key_sequencer.sv
// tb_aes_key_sequencer: directed vectors plus hand sequences for timeout, reset abort and ignored strobes.
module tb_aes_key_sequencer;
    localparam logic [127:0] XK = {4{32'h5A5AA5A5}};
    typedef struct {
        logic [31:0]  addr;
        logic [31:0]  kbase;
        logic [127:0] d;
        int           dly;
        int           lat;
        int           exp_lat;
        logic [31:0]  a [4];
    } vec_t;
    logic         clk, nrst, aes_start, mem_req, mem_ack, core_start, aes_done, busy, aes_err;
    logic [31:0]  key_addr, mem_addr, mem_rdata, r0, r1, r2, r3;
    logic [127:0] din_in, core_key, core_din, model_dout;
    logic         core_done_m, core_done_inj;
    logic [31:0]  base, kbase;
    logic [31:0]  rec [4];
    logic [127:0] last_res;
    int ack_delay, done_lat, nacks, stab_err, early_cs, done_cnt, cs_cnt, done_cyc, cyc;
    int total, bad;
    vec_t vt [5];
    aes_key_sequencer #(.TIMEOUT(16)) dut (
        .clk(clk), .nrst(nrst), .aes_start(aes_start),
        .AES_D0_I(din_in[127:96]), .AES_D1_I(din_in[95:64]),
        .AES_D2_I(din_in[63:32]), .AES_D3_I(din_in[31:0]),
        .AES_key_addr_I(key_addr),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .core_start(core_start), .core_key(core_key), .core_din(core_din),
        .core_dout(core_done_inj ? {4{32'hDEADBEEF}} : model_dout),
        .core_done(core_done_m | core_done_inj),
        .AES_Res0_O(r0), .AES_Res1_O(r1), .AES_Res2_O(r2), .AES_Res3_O(r3),
        .aes_done(aes_done), .busy(busy), .aes_err(aes_err)
    );
    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end
    initial begin
        cyc = 0;
        forever begin @(posedge clk); cyc++; end
    end
    initial begin
        done_cnt = 0; cs_cnt = 0; done_cyc = 0;
        forever begin
            @(negedge clk);
            if (aes_done) begin done_cnt++; done_cyc = cyc; end
            if (core_start) cs_cnt++;
        end
    end
    // memory responder: ack tied high when ack_delay==0, else ack_delay idle cycles before each ack
    initial begin
        automatic int wcnt = 0;
        automatic bit pend = 0;
        mem_ack = 0; mem_rdata = 0; nacks = 0; stab_err = 0; early_cs = 0;
        forever begin
            @(negedge clk);
            if (pend) nacks++;
            if (!busy) nacks = 0;
            if (core_start && nacks != 4) early_cs++;
            if (busy && nacks < 4 && !mem_req) stab_err++;
            if (ack_delay == 0) mem_ack = 1;
            else if (mem_req && wcnt == ack_delay) begin mem_ack = 1; wcnt = 0; end
            else begin mem_ack = 0; wcnt = mem_req ? wcnt + 1 : 0; end
            pend = mem_req && mem_ack;
            if (mem_req) begin
                if (mem_addr != base + 32'(4 * nacks)) stab_err++;
                mem_rdata = kbase + ((mem_addr - base) >> 2);
                if (mem_ack && nacks < 4) rec[nacks] = mem_addr;
            end
        end
    end
    // AES core stand-in: result is plaintext ^ key ^ XK, done_lat cycles after core_start
    initial begin
        automatic int ccnt = 0;
        automatic bit armed = 0;
        core_done_m = 0; model_dout = 0;
        forever begin
            @(negedge clk);
            if (core_start) begin armed = 1; ccnt = 0; end
            else if (armed) ccnt++;
            if (!busy) armed = 0;
            core_done_m = armed && ccnt == done_lat;
            if (core_done_m) armed = 0;
            model_dout = core_din ^ core_key ^ XK;
        end
    end
    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask
    function automatic vec_t mk(input logic [31:0] addr, input logic [31:0] kb, input logic [127:0] d,
                                input int dly, input int lat, input int el,
                                input logic [31:0] a0, input logic [31:0] a1,
                                input logic [31:0] a2, input logic [31:0] a3);
        vec_t v;
        v.addr = addr; v.kbase = kb; v.d = d; v.dly = dly; v.lat = lat; v.exp_lat = el;
        v.a[0] = a0; v.a[1] = a1; v.a[2] = a2; v.a[3] = a3;
        return v;
    endfunction
    task automatic tick();
        @(negedge clk); #1;
    endtask
    task automatic start(input logic [31:0] addr, input logic [31:0] kb, input logic [127:0] d,
                         input int dly, input int lat);
        base = addr; kbase = kb; ack_delay = dly; done_lat = lat;
        @(negedge clk);
        din_in = d; key_addr = addr; aes_start = 1;
        tick();
        aes_start = 0; din_in = ~d; key_addr = addr ^ 32'h80;
    endtask
    task automatic wait_cs(input int cs0);
        int n;
        n = 0;
        while (cs_cnt == cs0 && n < 200) begin tick(); n++; end
        chk("cs_seen", 128'(cs_cnt - cs0), 128'(1));
    endtask
    task automatic run(input vec_t v, input bit poke);
        int dn0, cs0, se0, ec0, t0, n;
        logic [127:0] ek;
        dn0 = done_cnt; cs0 = cs_cnt; se0 = stab_err; ec0 = early_cs;
        ek = {v.kbase, v.kbase + 32'd1, v.kbase + 32'd2, v.kbase + 32'd3};
        start(v.addr, v.kbase, v.d, v.dly, v.lat);
        t0 = cyc;
        chk("err_clr", 128'(aes_err), 128'(0));
        chk("busy_run", 128'(busy), 128'(1));
        if (poke) begin
            wait_cs(cs0);
            tick();
            aes_start = 1; din_in = 128'hFEED; key_addr = 32'h9999_0000;
            tick();
            aes_start = 0;
        end
        n = 0;
        while (done_cnt == dn0 && n < 300) begin tick(); n++; end
        chk("done_seen", 128'(done_cnt - dn0), 128'(1));
        chk("latency", 128'(done_cyc - t0), 128'(v.exp_lat));
        for (int i = 0; i < 4; i++) chk($sformatf("addr%0d", i), 128'(rec[i]), 128'(v.a[i]));
        chk("core_key", core_key, ek);
        chk("core_din", core_din, v.d);
        chk("result", {r0, r1, r2, r3}, v.d ^ ek ^ XK);
        repeat (3) tick();
        chk("one_done", 128'(done_cnt - dn0), 128'(1));
        chk("one_start", 128'(cs_cnt - cs0), 128'(1));
        chk("idle_after", 128'(busy), 128'(0));
        chk("no_err", 128'(aes_err), 128'(0));
        chk("stable", 128'(stab_err - se0), 128'(0));
        chk("early_cs", 128'(early_cs - ec0), 128'(0));
        last_res = v.d ^ ek ^ XK;
    endtask
    task automatic chk_zero(input string tag);
        chk({tag, "_ctl"}, 128'({mem_req, core_start, aes_done, busy, aes_err, mem_addr}), 128'(0));
        chk({tag, "_key"}, core_key, 128'(0));
        chk({tag, "_din"}, core_din, 128'(0));
        chk({tag, "_res"}, {r0, r1, r2, r3}, 128'(0));
    endtask
    task automatic inject_done(input string tag);
        int dn0;
        dn0 = done_cnt;
        @(negedge clk); core_done_inj = 1;
        @(negedge clk); core_done_inj = 0;
        repeat (3) tick();
        chk({tag, "_busy"}, 128'(busy), 128'(0));
        chk({tag, "_nodone"}, 128'(done_cnt - dn0), 128'(0));
        chk({tag, "_res"}, {r0, r1, r2, r3}, last_res);
    endtask
    initial begin
        int cs0, dn0, t1, n;
        total = 0; bad = 0; last_res = 0;
        aes_start = 0; din_in = 0; key_addr = 0; core_done_inj = 0;
        base = 0; kbase = 0; ack_delay = 0; done_lat = -1;
        vt[0] = mk(32'h0000_0100, 32'h0000_00A0, 128'h00112233_44556677_8899AABB_CCDDEEFF, 0, 10, 15,
                   32'h100, 32'h104, 32'h108, 32'h10C);
        vt[1] = mk(32'hFFFF_FFF8, 32'h0000_1000, 128'hDEADBEEF_01234567_89ABCDEF_FEDCBA98, 0, 2, 7,
                   32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4);
        vt[2] = mk(32'h0000_2000, 32'hBEEF_0000, 128'h11111111_22222222_33333333_44444444, 3, 0, 17,
                   32'h2000, 32'h2004, 32'h2008, 32'h200C);
        vt[3] = mk(32'h0000_0010, 32'h0000_0007, 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0, 1, 15, 24,
                   32'h10, 32'h14, 32'h18, 32'h1C);
        vt[4] = mk(32'hFFFF_FFFC, 32'hCAFE_0000, 128'h0BADF00D_CAFEBABE_12345678_9ABCDEF0, 0, 14, 19,
                   32'hFFFF_FFFC, 32'h0, 32'h4, 32'h8);
        nrst = 1;
        #1 nrst = 0;
        #1 chk_zero("reset");
        repeat (2) @(negedge clk);
        nrst = 1;
        for (int i = 0; i < 5; i++) run(vt[i], i == 0);
        inject_done("idle_done");
        // core never answers: 16 RUN cycles then abort with aes_err
        cs0 = cs_cnt; dn0 = done_cnt;
        start(32'h300, 32'h50, 128'h77, 0, -1);
        wait_cs(cs0);
        t1 = cyc; n = 0;
        while (busy && n < 100) begin tick(); n++; end
        chk("tmo_cycles", 128'(cyc - t1), 128'(16));
        chk("tmo_err", 128'(aes_err), 128'(1));
        chk("tmo_busy", 128'(busy), 128'(0));
        chk("tmo_nodone", 128'(done_cnt - dn0), 128'(0));
        chk("tmo_res", {r0, r1, r2, r3}, last_res);
        repeat (2) tick();
        chk("tmo_sticky", 128'(aes_err), 128'(1));
        run(vt[1], 0);
        // abort during the wait on key word 2
        start(32'h400, 32'h60, 128'h88, 3, 5);
        n = 0;
        while (nacks != 2 && n < 100) begin tick(); n++; end
        chk("fetch_w2", 128'(nacks), 128'(2));
        @(negedge clk);
        #2 nrst = 0;
        #1 chk_zero("rst_fetch");
        @(negedge clk); nrst = 1;
        last_res = 0;
        run(vt[2], 0);
        // abort mid-RUN, late core_done must be ignored
        cs0 = cs_cnt;
        start(32'h500, 32'h70, 128'h99, 0, -1);
        wait_cs(cs0);
        tick();
        #2 nrst = 0;
        #1 chk_zero("rst_run");
        @(negedge clk); nrst = 1;
        last_res = 0;
        inject_done("late_done");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/aes_key_sequencer.md
AES_KEY_SEQUENCER -- requirements
Module: aes_key_sequencer

Interface
REQ-001 Parameter TIMEOUT, default 1024: maximum number of RUN cycles to wait for core_done; a value of 0 disables the timeout.
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 nrst  in  1  reset, asynchronous, active-low.
REQ-004 aes_start  in  1  request pulse; sampled only in IDLE.
REQ-005 AES_D0_I..AES_D3_I  in  32 each  plaintext words; D0 maps to block bits [127:96], D3 to [31:0].
REQ-006 AES_key_addr_I  in  32  byte address of key word 0.
REQ-007 mem_req  out  1  key read request; held high until mem_ack.
REQ-008 mem_addr  out  32  key read address.
REQ-009 mem_rdata  in  32  read data; valid when mem_ack is high.
REQ-010 mem_ack  in  1  read completion; may rise in the same cycle as mem_req.
REQ-011 core_start  out  1  one-cycle pulse that starts the AES core.
REQ-012 core_key  out  128  latched key; key word 0 maps to bits [127:96].
REQ-013 core_din  out  128  latched plaintext block.
REQ-014 core_dout  in  128  core result; valid when core_done is high.
REQ-015 core_done  in  1  one-cycle completion pulse from the core.
REQ-016 AES_Res0_O..AES_Res3_O  out  32 each  result words; Res0 is core_dout[127:96].
REQ-017 aes_done  out  1  one-cycle pulse indicating the results are valid.
REQ-018 busy  out  1  high in every state except IDLE.
REQ-019 aes_err  out  1  sticky timeout flag; cleared by the next accepted aes_start.

Function
REQ-020 The block SHALL implement the states IDLE, FETCH, RUN and DONE, encoded in a 2-bit state register.
REQ-021 In IDLE, aes_start=1 at a clock edge SHALL latch AES_D0_I..AES_D3_I into core_din, latch AES_key_addr_I, clear the word index and aes_err, and move to FETCH.
REQ-022 In FETCH, mem_req=1 and mem_addr=latched_addr+4*index, computed modulo 2^32 so that wrap-around is allowed.
REQ-023 On each FETCH edge with mem_ack=1, mem_rdata SHALL be stored as key word[index] and index SHALL increment; mem_addr SHALL stay stable while mem_ack=0.
REQ-024 The ack for word 3 SHALL move the block to RUN, and core_start SHALL be 1 for exactly the first RUN cycle.
REQ-025 In RUN, core_done=1 SHALL capture core_dout into AES_Res0_O..AES_Res3_O and move the block to DONE; core_done outside RUN SHALL be ignored.
REQ-026 The DONE state SHALL last one cycle with aes_done=1, then return to IDLE; the result registers SHALL hold their values until the next capture.
REQ-027 When TIMEOUT>0, a RUN cycle counter reaching TIMEOUT without core_done SHALL set aes_err=1, leave the result registers unchanged, and return to IDLE without an aes_done pulse.
REQ-028 aes_start while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-029 core_done and a timeout arriving in the same cycle SHALL be treated as done, with no error.
REQ-030 With mem_ack tied high, latency from the accepting aes_start edge to aes_done=1 SHALL be 4 FETCH cycles + N RUN cycles + 1 cycle, where N is the number of RUN cycles until core_done.
REQ-031 Input changes on AES_D*_I or AES_key_addr_I after acceptance SHALL NOT affect the operation in progress.

Reset
REQ-032 nrst=0 SHALL immediately force IDLE and clear index, the timeout counter, core_key, core_din, all AES_Res*_O, aes_done, core_start, mem_req, mem_addr, busy and aes_err to 0.
REQ-033 Reset asserted mid-FETCH or mid-RUN SHALL abandon the operation; a core_done arriving after reset SHALL be ignored.

Verification
REQ-034 key_addr=0x100, mem_ack tied 1, key words 0xA0..0xA3, core_done 10 cycles after core_start -> mem_addr sequence 0x100/0x104/0x108/0x10C, core_key={A0,A1,A2,A3}, one aes_done pulse, Res0..3 equal core_dout words.
REQ-035 key_addr=0xFFFFFFF8 -> mem_addr sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
REQ-036 mem_ack delayed by 3 cycles per word -> mem_req and mem_addr held stable through each wait, and core_start occurs only after the 4th ack.
REQ-037 aes_start pulsed during RUN, and core_done pulsed in IDLE -> no state change, no extra aes_done, results unchanged.
REQ-038 TIMEOUT=16, core_done never asserted -> aes_err=1 after 16 RUN cycles, busy=0, no aes_done; the next aes_start clears aes_err.
REQ-039 nrst pulsed low during FETCH word 2 -> all outputs 0 immediately; a new start then fetches from word 0.
